// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family: FSM encoding, counter sizing and
// the product width used by the ALU top.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int ALU_WIDTH = 32;
   localparam int PROD_W    = 2 * ALU_WIDTH;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/twos_mag.sv
// Combinational two's-complement conditional negate; with neg tied to the sign bit
// it yields the magnitude (the most negative value maps onto its unsigned magnitude).
module twos_mag #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? -x : x;

endmodule

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with valid/ready handshakes, one multiplier bit per clock.
// Optional SEQ_MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are all zero.
module seq_mult_hs
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   c
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic             neg;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [PW-1:0]    acc_next;
   logic [PW-1:0]    prod_fix;
   logic             accept;
   logic             last;

   twos_mag #(.W(WIDTH)) u_mag_a (.x(a), .neg(is_signed & a[WIDTH-1]), .y(a_mag));
   twos_mag #(.W(WIDTH)) u_mag_b (.x(b), .neg(is_signed & b[WIDTH-1]), .y(b_mag));

   assign accept   = in_valid && in_ready;
   assign acc_next = acc + (mplier[0] ? mcand : '0);

   // Sign fix is applied to the sum being formed on the exit edge, so c is final when flagged.
   twos_mag #(.W(PW)) u_fix (.x(acc_next), .neg(neg), .y(prod_fix));

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign last = (cnt == CW'(1)) || (mplier[WIDTH-1:1] == '0);
`else
   assign last = (cnt == CW'(1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         c         <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= CALC;
                  in_ready <= 1'b0;
                  cnt      <= CW'(WIDTH);
               end
            end
            CALC: begin
               cnt <= cnt - CW'(1);
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  c         <= prod_fix;
                  cnt       <= '0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Datapath registers carry no reset; they are always reloaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand  <= PW'(a_mag);
         mplier <= b_mag;
         acc    <= '0;
         neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == CALC) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Scoreboard bench for seq_mult_hs (WIDTH=32): directed cases plus randomized operands.
module tb_seq_mult_hs;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          is_signed = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [2*W-1:0] c;

   seq_mult_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .c(c)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] c;
      int          acc_edge;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   rise_cyc = 0;
   logic prev_ov = 1'b0;

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      longint          sx, sy;
      longint unsigned ux, uy;
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      ux = {32'b0, x};
      uy = {32'b0, y};
      return ux * uy;
   endfunction

   function automatic int model_lat(input logic [31:0] y, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
      longint unsigned m;
      int hb;
      m  = (s && y[31]) ? longint'(64'd4294967296 - {32'b0, y}) : {32'b0, y};
      hb = -1;
      for (int i = 0; i < 33; i++) if (m[i]) hb = i;
      return (hb < 0) ? 1 : hb + 1;
`else
      return (s || !s) ? 32 : 0;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && !prev_ov) rise_cyc = cyc;
         prev_ov = out_valid;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got c=0x%h, expected no output", c);
            end else begin
               e = sb.pop_front();
               check("product", c, e.c);
               check("latency", 64'(rise_cyc - e.acc_edge), 64'(e.lat));
            end
         end
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic issue_c(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                          input logic [63:0] expc);
      exp_t e;
      int   k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_timeout: got in_ready=0, expected 1 within 300 cycles");
         return;
      end
      a = ia;
      b = ib;
      is_signed = s;
      in_valid = 1'b1;
      e.c = expc;
      e.acc_edge = cyc + 1;
      e.lat = model_lat(ib, s);
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic s);
      issue_c(ia, ib, s, model(ia, ib, s));
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [31:0] pick(input int unsigned sel);
      case (sel % 8)
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] held;
      int          k;

      repeat (3) @(negedge clk);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_c", c, 64'd0);
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      rst_n = 1'b1;

      // Unsigned, signed and mode-contrast directed products.
      issue_c(32'd15, 32'hFFFF_FFFF, 1'b0, 64'h0000_000E_FFFF_FFF1);
      check("calc_in_ready", {63'b0, in_ready}, 64'd0);
      drain();
      issue_c(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      issue_c(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      issue_c(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
      issue_c(32'h8000_0000, 32'd1, 1'b0, 64'h0000_0000_8000_0000);
      issue_c(32'hFFFF_FFF0, 32'd0, 1'b1, 64'd0);
      drain();

      // Backpressure: output held, new request ignored while DONE.
      out_ready = 1'b0;
      issue(32'd1234, 32'd5678, 1'b0);
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      held = c;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_c_stable", c, held);
         check("bp_out_valid", {63'b0, out_valid}, 64'd1);
         check("bp_in_ready", {63'b0, in_ready}, 64'd0);
         if (i == 1) begin
            a = 32'd99;
            b = 32'd99;
            in_valid = 1'b1;
         end
         if (i == 2) in_valid = 1'b0;
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
      issue(32'd77, 32'hFFFF_FFFB, 1'b1);
      drain();

      // Asynchronous reset in the middle of a calculation.
      issue(32'd12345, 32'd678, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("mid_rst_c", c, 64'd0);
      check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue_c(32'd6, 32'd7, 1'b0, 64'd42);
      drain();

`ifdef SEQ_MULT_EARLY_TERM_EN
      issue_c(32'hDEAD_BEEF, 32'd1, 1'b0, 64'h0000_0000_DEAD_BEEF);
      issue_c(32'd5, 32'd0, 1'b0, 64'd0);
      issue_c(32'd2, 32'h8000_0000, 1'b0, 64'h0000_0001_0000_0000);
      drain();
`endif

      // Randomized operands with a bias towards boundary values.
      for (int i = 0; i < 30; i++) begin
         issue(pick($urandom), pick($urandom), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
